// File: rtl/div_issue_pkg.sv
// div_issue_pkg: shared state encoding and constants for the divider issue controller
package div_issue_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, COOL} state_t;
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_issue_if.sv
// div_issue_if: request/response link between the issue controller and the iterative divider
interface div_issue_if;
  logic        div;
  logic        div_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] s;
  logic [31:0] r;
  logic        complete;
  modport master (output div, div_signed, x, y, input s, r, complete);
  modport slave (input div, div_signed, x, y, output s, r, complete);
endinterface

// File: rtl/div_issue_hilo_regs.sv
// div_issue_hilo_regs: architectural HI/LO with divider results taking priority over MTHI/MTLO
module div_issue_hilo_regs #(
  parameter logic [31:0] RESET_HI = 32'h0,
  parameter logic [31:0] RESET_LO = 32'h0
) (
  input  logic        div_clk,
  input  logic        resetn,
  input  logic        res_we,
  input  logic [31:0] res_hi,
  input  logic [31:0] res_lo,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  // divider result beats a same-edge move-to write for both registers
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      hi <= RESET_HI;
      lo <= RESET_LO;
    end else begin
      hi <= res_we ? res_hi : mthi_we ? mt_data : hi;
      lo <= res_we ? res_lo : mtlo_we ? mt_data : lo;
    end
  end
endmodule

// File: rtl/div_issue.sv
// div_issue: issues DIV/DIVU to the iterative divider, stalls the pipeline and owns HI/LO
module div_issue
  import div_issue_pkg::*;
#(
  parameter logic [31:0] RESET_HI = 32'h0,
  parameter logic [31:0] RESET_LO = 32'h0
) (
  input  logic         div_clk,
  input  logic         resetn,
  input  logic         op_valid,
  input  logic         op_signed,
  input  logic [31:0]  op_a,
  input  logic [31:0]  op_b,
  input  logic         op_cancel,
  input  logic         mthi_we,
  input  logic         mtlo_we,
  input  logic [31:0]  mt_data,
  output logic         stall,
  div_issue_if.master  dbus,
  output logic [31:0]  hi,
  output logic [31:0]  lo
);
  state_t state, state_n;
  logic zero_div, accept, res_we;
  logic [31:0] res_hi, res_lo;
  assign zero_div = op_b == '0;
  assign res_hi = (state == BUSY) ? dbus.r : op_a;
  assign res_lo = (state == BUSY) ? dbus.s : DIV_ZERO_LO;
  // next state, stall and result-write decode; divide by zero resolves in IDLE without the divider
  always_comb begin
    state_n = state;
    stall = 1'b0;
    accept = 1'b0;
    res_we = 1'b0;
    case (state)
      IDLE: begin
        accept = op_valid && !op_cancel && !zero_div;
        res_we = op_valid && !op_cancel && zero_div;
        stall = op_valid && !zero_div;
        state_n = accept ? BUSY : IDLE;
      end
      BUSY: begin
        stall = 1'b1;
        res_we = dbus.complete && !op_cancel;
        state_n = op_cancel ? COOL : dbus.complete ? DRAIN : BUSY;
      end
      DRAIN: begin
        stall = op_valid;
        state_n = dbus.complete ? DRAIN : IDLE;
      end
      COOL: begin
        stall = op_valid;
        state_n = IDLE;
      end
    endcase
  end
  // state register, divider request level and operand latches held for the whole divide
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      state <= IDLE;
      dbus.div <= 1'b0;
      dbus.div_signed <= 1'b0;
      dbus.x <= '0;
      dbus.y <= '0;
    end else begin
      state <= state_n;
      dbus.div <= state_n == BUSY;
      if (accept) begin
        dbus.div_signed <= op_signed;
        dbus.x <= op_a;
        dbus.y <= op_b;
      end
    end
  end
  div_issue_hilo_regs #(.RESET_HI(RESET_HI), .RESET_LO(RESET_LO)) hilo_regs (
    .div_clk (div_clk),
    .resetn  (resetn),
    .res_we  (res_we),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .mthi_we (mthi_we),
    .mtlo_we (mtlo_we),
    .mt_data (mt_data),
    .hi      (hi),
    .lo      (lo)
  );
endmodule
